// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned multiplier with HI/LO result registers.
// Shift-add datapath retiring one multiplier bit per clock.
module multu_hilo #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001,
    parameter logic [5:0]  MFHI  = 6'b010000,
    parameter logic [5:0]  MFLO  = 6'b010010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;

    logic               launch;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nx;

    // One shift-add step: conditional add into the upper half, then shift right.
    always_comb begin
        launch = start && (Signal == MULTU);
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nx = {sum, acc[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; busy/done are registered with the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (launch) begin
                        mcand  <= dataA;
                        mplier <= dataB;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_nx;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi    <= acc_nx[2*WIDTH-1:WIDTH];
                        lo    <= acc_nx[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read port for MFHI/MFLO, valid in every state.
    always_comb begin
        dataOut = '0;
        unique case (1'b1)
            (Signal == MFHI): dataOut = hi;
            (Signal == MFLO): dataOut = lo;
            default:          dataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Directed-vector bench for multu_hilo.
// Inputs change and outputs are sampled on the falling edge.
module tb_multu_hilo;

    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dataOut;

    int ntests = 0;
    int nfail  = 0;

    multu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    // Present a MULTU request; returns at the falling edge after acceptance.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        Signal = OP_MULTU;
        dataA  = a;
        dataB  = b;
        @(negedge clk);
        start  = 1'b0;
        Signal = 6'b000000;
    endtask

    // Count falling edges until done; cyc=-1 on timeout. busy cycles counted too.
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = -1;
        nbusy = busy ? 1 : 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        start  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = '0;
        repeat (3) @(negedge clk);
        ntests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            nfail++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     busy, done, hi, lo);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small;
        int cyc, nb;
        launch(32'd3, 32'd5);
        ntests++;
        if (busy !== 1'b1) begin
            nfail++;
            $display("FAIL small_busy: busy=%b want 1", busy);
        end
        wait_done(cyc, nb);
        ntests++;
        if (cyc != 32 || nb != 32) begin
            nfail++;
            $display("FAIL small_latency: done_at=%0d busy_cycles=%0d want 32 32",
                     cyc, nb);
        end
        ntests++;
        if (hi !== 32'h0 || lo !== 32'hF) begin
            nfail++;
            $display("FAIL small_result: hi=%h lo=%h want 00000000 0000000f", hi, lo);
        end
        Signal = OP_MFLO;
        #1;
        ntests++;
        if (dataOut !== 32'hF) begin
            nfail++;
            $display("FAIL small_mflo: dataOut=%h want 0000000f", dataOut);
        end
        @(negedge clk);
        ntests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL small_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_max;
        int cyc, nb;
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, nb);
        ntests++;
        if (cyc != 32 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            nfail++;
            $display("FAIL max_result: cyc=%0d hi=%h lo=%h want 32 fffffffe 00000001",
                     cyc, hi, lo);
        end
        Signal = OP_MFHI;
        #1;
        ntests++;
        if (dataOut !== 32'hFFFF_FFFE) begin
            nfail++;
            $display("FAIL max_mfhi: dataOut=%h want fffffffe", dataOut);
        end
        Signal = 6'b100000;
        #1;
        ntests++;
        if (dataOut !== 32'h0) begin
            nfail++;
            $display("FAIL other_sig: dataOut=%h want 00000000", dataOut);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int cyc, nb, ndone;
        launch(32'h0001_0000, 32'h0001_0000);
        repeat (9) @(negedge clk);
        launch(32'd7, 32'd9);
        dataA = 32'hDEAD_BEEF;
        dataB = 32'hCAFE_F00D;
        wait_done(cyc, nb);
        ntests++;
        if (cyc != 22 || hi !== 32'h1 || lo !== 32'h0) begin
            nfail++;
            $display("FAIL ignore_result: cyc=%0d hi=%h lo=%h want 22 00000001 00000000",
                     cyc, hi, lo);
        end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        ntests++;
        if (ndone != 0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL ignore_once: extra_done=%0d busy=%b want 0 0", ndone, busy);
        end
    endtask

    task automatic test_reset_midrun;
        int cyc, nb, ndone;
        launch(32'd3, 32'd5);
        wait_done(cyc, nb);
        @(negedge clk);
        launch(32'h1234_5678, 32'h10);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ntests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            nfail++;
            $display("FAIL midrun_reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     busy, done, hi, lo);
        end
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        ntests++;
        if (ndone != 0) begin
            nfail++;
            $display("FAIL midrun_quiet: active_cycles=%0d want 0", ndone);
        end
        launch(32'd2, 32'd2);
        wait_done(cyc, nb);
        ntests++;
        if (cyc != 32 || hi !== 32'h0 || lo !== 32'd4) begin
            nfail++;
            $display("FAIL after_reset: cyc=%0d hi=%h lo=%h want 32 00000000 00000004",
                     cyc, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc, nb;
        launch(32'd3, 32'd5);
        wait_done(cyc, nb);
        launch(32'd6, 32'd7);
        ntests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
        end
        repeat (5) @(negedge clk);
        Signal = OP_MFLO;
        #1;
        ntests++;
        if (dataOut !== 32'hF || busy !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_old_lo: dataOut=%h busy=%b want 0000000f 1", dataOut, busy);
        end
        wait_done(cyc, nb);
        ntests++;
        if (cyc != 27 || lo !== 32'd42 || hi !== 32'h0) begin
            nfail++;
            $display("FAIL b2b_result: cyc=%0d hi=%h lo=%h want 27 00000000 0000002a",
                     cyc, hi, lo);
        end
        Signal = 6'b000000;
        @(negedge clk);
    endtask

    task automatic test_non_multu_start;
        int nact;
        start  = 1'b1;
        Signal = OP_MFHI;
        dataA  = 32'd100;
        dataB  = 32'd100;
        nact   = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || done) nact++;
        end
        start = 1'b0;
        ntests++;
        if (nact != 0 || hi !== 32'h0 || lo !== 32'd42 || dataOut !== 32'h0) begin
            nfail++;
            $display("FAIL no_launch: active=%0d hi=%h lo=%h dataOut=%h want 0 0 2a 0",
                     nact, hi, lo, dataOut);
        end
        Signal = 6'b000000;
    endtask

    initial begin
        test_reset;
        test_small;
        test_max;
        test_ignore_start;
        test_reset_midrun;
        test_back_to_back;
        test_non_multu_start;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
- Sequential 32x32 unsigned multiplier (MULTU) with HI/LO result registers.
- Sits beside the combinational ALU in the execute stage and shares its dataA/dataB/Signal operand bus.
- Its dataOut is muxed with the ALU dataOut downstream; MFHI/MFLO read the registered product.
- Shift-add datapath, one multiplier bit per cycle.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH split into HI (upper) and LO (lower).
- MULTU, 6'b011001, Signal code that starts a multiply when qualified by start.
- MFHI, 6'b010000, Signal code selecting HI onto dataOut.
- MFLO, 6'b010010, Signal code selecting LO onto dataOut.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request strobe; a multiply launches only when start=1 and Signal==MULTU.
- dataA  input  WIDTH  multiplicand.
- dataB  input  WIDTH  multiplier.
- Signal  input  6  function code (MULTU/MFHI/MFLO; others are no-ops for this block).
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when HI/LO receive a new product.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- dataOut  output  WIDTH  HI if Signal==MFHI, LO if Signal==MFLO, else 0 (combinational from registers).

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0; internal product/multiplicand/multiplier registers=0. Reset overrides everything, including a multiply in flight, and produces no done pulse.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasting exactly one cycle.
- Accept: at edge E0, if state is IDLE or DONE, start=1 and Signal==MULTU:
  - latch dataA and dataB;
  - clear the 2*WIDTH accumulator and set counter=0;
  - go to RUN.
  - start with any other Signal is ignored.
- RUN iteration (edges E1..E32):
  - if the multiplier LSB=1, add the multiplicand (zero-extended, WIDTH+1-bit sum keeps the carry) into the accumulator upper half;
  - shift accumulator right 1 with carry in at the top, and shift the multiplier right 1;
  - counter increments.
- Completion:
  - at edge E32 (counter reaches WIDTH-1 and iterates), hi=product[2W-1:W], lo=product[W-1:0], state goes to DONE.
  - Total latency: done is high in the cycle after E32, i.e. 32 cycles after acceptance.
- DONE: next edge goes to IDLE, or directly back to RUN if a new valid start is present (back-to-back accepted, no bubble).
- start during RUN is ignored; operands are not re-latched; the in-flight result is unaffected.
- hi/lo hold the previous product for the whole RUN and change only at the completion edge or at reset.
- Changes on dataA/dataB during RUN have no effect.
- Arithmetic is unsigned only, with no overflow: the full 64-bit product is always exact.
- dataOut is valid in any state, including during RUN, where it returns the old HI/LO.

Test Plan:
- Reset, then start, Signal=MULTU, A=3, B=5 -> busy 1 for 32 cycles; done pulse in cycle 33 after accept; hi=0x00000000, lo=0x0000000F; Signal=MFLO gives dataOut=0x0000000F.
- A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MFHI gives dataOut=0xFFFFFFFE; Signal=6'b100000 gives dataOut=0.
- Accept A=0x00010000, B=0x00010000; at cycle 10 assert start with A=7, B=9 -> ignored; result hi=0x00000001, lo=0x00000000; exactly one done pulse.
- Complete 3*5, then start 0x12345678*0x10 and pull reset low at cycle 10 of RUN -> next cycle busy=0, hi=lo=0, no done pulse; after release a new 2*2 gives lo=4.
- Hold start=1 with Signal=MULTU during the done cycle with new operands 6*7 -> accepted with no IDLE cycle; second done arrives 32 cycles later with lo=42; during the second RUN, MFLO still reads the first product.
- start=1 with Signal=MFHI (not MULTU) -> no launch, busy stays 0, hi/lo unchanged.
